// File: rtl/osd_mam_arb.sv
// Round-robin arbiter sharing one MAM memory-access port between N requesters.
// A grant covers one whole transaction: request, every data beat, then release.
module osd_mam_arb #(
  parameter int N          = 2,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N-1:0]              req_valid,
  output logic [N-1:0]              req_ready,
  input  logic [N-1:0]              req_rw,
  input  logic [N*ADDR_WIDTH-1:0]   req_addr,
  input  logic [N-1:0]              req_burst,
  input  logic [N*14-1:0]           req_beats,
  input  logic [N-1:0]              write_valid,
  input  logic [N*DATA_WIDTH-1:0]   write_data,
  input  logic [N*DATA_WIDTH/8-1:0] write_strb,
  output logic [N-1:0]              write_ready,
  output logic [N-1:0]              read_valid,
  output logic [DATA_WIDTH-1:0]     read_data,
  input  logic [N-1:0]              read_ready,
  output logic                      m_req_valid,
  output logic                      m_req_rw,
  output logic [ADDR_WIDTH-1:0]     m_req_addr,
  output logic                      m_req_burst,
  output logic [13:0]               m_req_beats,
  input  logic                      m_req_ready,
  output logic                      m_write_valid,
  output logic [DATA_WIDTH-1:0]     m_write_data,
  output logic [DATA_WIDTH/8-1:0]   m_write_strb,
  input  logic                      m_write_ready,
  input  logic                      m_read_valid,
  input  logic [DATA_WIDTH-1:0]     m_read_data,
  output logic                      m_read_ready,
  output logic [N-1:0]              grant
);
  localparam int GW = $clog2(N);
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WDATA = 2'd2, RDATA = 2'd3} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] g_q, g_d, ptr_q, ptr_d;
  logic [13:0]   cnt_q, cnt_d;
  logic          rw_q, rw_d;

  logic [ADDR_WIDTH-1:0] addr_a  [N];
  logic [13:0]           beats_a [N];
  logic [DATA_WIDTH-1:0] wdata_a [N];
  logic [SW-1:0]         wstrb_a [N];

  for (genvar i = 0; i < N; i++) begin : g_slice
    assign addr_a[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign beats_a[i] = req_beats[i*14 +: 14];
    assign wdata_a[i] = write_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign wstrb_a[i] = write_strb[i*SW +: SW];
  end

  logic [N-1:0]  g_oh_s;
  logic [GW-1:0] next_ptr_s, hi_sel_s, lo_sel_s, sel_s;
  logic          hi_found_s, lo_found_s;

  assign g_oh_s     = N'(1) << g_q;
  assign next_ptr_s = (g_q == GW'(N - 1)) ? '0 : g_q + GW'(1);

  // Rotating priority: lowest requester at or above ptr wins, else lowest overall
  always_comb begin
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_sel_s   = '0;
    lo_sel_s   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      lo_sel_s   = req_valid[i] ? GW'(i) : lo_sel_s;
      lo_found_s = lo_found_s | req_valid[i];
      hi_sel_s   = (req_valid[i] && (GW'(i) >= ptr_q)) ? GW'(i) : hi_sel_s;
      hi_found_s = hi_found_s | (req_valid[i] && (GW'(i) >= ptr_q));
    end
    sel_s = hi_found_s ? hi_sel_s : lo_sel_s;
  end

  // Next-state logic and combinational routing of the granted requester
  always_comb begin
    state_d       = state_q;
    g_d           = g_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    rw_d          = rw_q;
    grant         = '0;
    req_ready     = '0;
    write_ready   = '0;
    read_valid    = '0;
    read_data     = '0;
    m_req_valid   = 1'b0;
    m_req_rw      = 1'b0;
    m_req_addr    = '0;
    m_req_burst   = 1'b0;
    m_req_beats   = 14'd0;
    m_write_valid = 1'b0;
    m_write_data  = '0;
    m_write_strb  = '0;
    m_read_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (lo_found_s) begin
          g_d     = sel_s;
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        grant       = g_oh_s;
        m_req_valid = req_valid[g_q];
        m_req_rw    = req_rw[g_q];
        m_req_addr  = addr_a[g_q];
        m_req_burst = req_burst[g_q];
        m_req_beats = beats_a[g_q];
        req_ready   = m_req_ready ? g_oh_s : '0;
        if (req_valid[g_q] && m_req_ready) begin
          rw_d    = req_rw[g_q];
          cnt_d   = (req_burst[g_q] && (beats_a[g_q] != 14'd0)) ? beats_a[g_q] : 14'd1;
          state_d = req_rw[g_q] ? WDATA : RDATA;
        end else begin
          state_d = REQ;
        end
      end
      WDATA: begin
        grant         = g_oh_s;
        m_write_valid = write_valid[g_q];
        m_write_data  = wdata_a[g_q];
        m_write_strb  = wstrb_a[g_q];
        write_ready   = m_write_ready ? g_oh_s : '0;
        if (write_valid[g_q] && m_write_ready) begin
          cnt_d = cnt_q - 14'd1;
          if (cnt_q == 14'd1) begin
            state_d = IDLE;
            ptr_d   = next_ptr_s;
          end else begin
            state_d = WDATA;
          end
        end else begin
          state_d = WDATA;
        end
      end
      RDATA: begin
        grant        = g_oh_s;
        read_valid   = m_read_valid ? g_oh_s : '0;
        read_data    = m_read_data;
        m_read_ready = read_ready[g_q];
        if (m_read_valid && read_ready[g_q]) begin
          cnt_d = cnt_q - 14'd1;
          if (cnt_q == 14'd1) begin
            state_d = IDLE;
            ptr_d   = next_ptr_s;
          end else begin
            state_d = RDATA;
          end
        end else begin
          state_d = RDATA;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
      cnt_q   <= 14'd0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
    end
  end
endmodule

// File: tb/tb_osd_mam_arb.sv
// Bench for osd_mam_arb: per-requester drivers, a downstream responder, and a
// transaction-level monitor/scoreboard with a round-robin reference model.
module tb_osd_mam_arb;
  localparam int N   = 3;
  localparam int DW  = 16;
  localparam int AW  = 32;
  localparam int SW  = DW / 8;
  localparam int LIM = 400;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic          burst;
    logic [13:0]   beats;
    logic [DW-1:0] data [8];
    logic [SW-1:0] strb [8];
  } txn_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;

  wire  [N-1:0]    req_valid, req_rw, req_burst, write_valid, read_ready;
  wire  [N*AW-1:0] req_addr;
  wire  [N*14-1:0] req_beats;
  wire  [N*DW-1:0] write_data;
  wire  [N*SW-1:0] write_strb;
  logic [N-1:0]    req_ready, write_ready, read_valid, grant;
  logic [DW-1:0]   read_data, m_write_data, m_read_data;
  logic            m_req_valid, m_req_rw, m_req_burst, m_req_ready;
  logic [AW-1:0]   m_req_addr;
  logic [13:0]     m_req_beats;
  logic            m_write_valid, m_write_ready, m_read_valid, m_read_ready;
  logic [SW-1:0]   m_write_strb;

  txn_t       stim_q [N][$];
  txn_t       exp_q  [N][$];
  wire [31:0] done_cnt [N];
  int         vectors = 0, miscompares = 0, n_issued = 0, ds_mode = 0, mon_k = 0;
  bit         tmo = 1'b0, end_req = 1'b0, mon_active = 1'b0;

  initial forever #5 clk_i = ~clk_i;

  osd_mam_arb #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_addr(req_addr),
    .req_burst(req_burst), .req_beats(req_beats),
    .write_valid(write_valid), .write_data(write_data), .write_strb(write_strb),
    .write_ready(write_ready), .read_valid(read_valid), .read_data(read_data),
    .read_ready(read_ready),
    .m_req_valid(m_req_valid), .m_req_rw(m_req_rw), .m_req_addr(m_req_addr),
    .m_req_burst(m_req_burst), .m_req_beats(m_req_beats), .m_req_ready(m_req_ready),
    .m_write_valid(m_write_valid), .m_write_data(m_write_data), .m_write_strb(m_write_strb),
    .m_write_ready(m_write_ready), .m_read_valid(m_read_valid), .m_read_data(m_read_data),
    .m_read_ready(m_read_ready), .grant(grant)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, req);
    end
  endtask

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] pend, input int p);
    for (int d = 0; d < N; d++)
      if (pend[(p + d) % N]) return N'(1) << ((p + d) % N);
    return '0;
  endfunction

  function automatic int beats_of(input txn_t t);
    return (t.burst && t.beats != 14'd0) ? int'(t.beats) : 1;
  endfunction

  function automatic txn_t mk(input logic rw, input logic [AW-1:0] a, input logic b,
                              input logic [13:0] bt);
    txn_t t;
    t.rw = rw; t.addr = a; t.burst = b; t.beats = bt;
    for (int k = 0; k < 8; k++) begin
      t.data[k] = DW'($urandom);
      t.strb[k] = SW'($urandom);
    end
    return t;
  endfunction

  task automatic issue(input int i, input txn_t t);
    stim_q[i].push_back(t);
    exp_q[i].push_back(t);
    n_issued++;
  endtask

  function automatic int sum_done();
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(done_cnt[i]);
    return s;
  endfunction

  task automatic wait_idle();
    int c = 0;
    while ((sum_done() != n_issued || mon_active) && c < 20000) begin
      @(posedge clk_i);
      c++;
    end
    if (c >= 20000) tmo = 1'b1;
  endtask

  // Requester drivers: each pops its own stimulus queue and runs one transaction at a time
  for (genvar gi = 0; gi < N; gi++) begin : g_req
    logic          rv = 1'b0, rrw = 1'b0, rb = 1'b0, wv = 1'b0, rr = 1'b0;
    logic [AW-1:0] ra = '0;
    logic [13:0]   rbt = '0;
    logic [DW-1:0] wd = '0;
    logic [SW-1:0] ws = '0;
    int            ndone = 0;
    assign req_valid[gi] = rv;
    assign req_rw[gi] = rrw;
    assign req_burst[gi] = rb;
    assign req_addr[gi*AW +: AW] = ra;
    assign req_beats[gi*14 +: 14] = rbt;
    assign write_valid[gi] = wv;
    assign write_data[gi*DW +: DW] = wd;
    assign write_strb[gi*SW +: SW] = ws;
    assign read_ready[gi] = rr;
    assign done_cnt[gi] = 32'(ndone);

    initial begin
      txn_t t;
      int   nb, k, to;
      bit   ab, hs;
      forever begin
        @(posedge clk_i); #1;
        if (rst_ni && stim_q[gi].size() != 0) begin
          t = stim_q[gi].pop_front();
          nb = beats_of(t);
          ab = 1'b0; hs = 1'b0; to = 0; k = 0;
          rv = 1'b1; rrw = t.rw; ra = t.addr; rb = t.burst; rbt = t.beats;
          do begin
            @(negedge clk_i);
            to++;
            ab = !rst_ni;
            hs = req_ready[gi];
          end while (!ab && !hs && to < LIM);
          @(posedge clk_i); #1;
          rv = 1'b0;
          while (hs && !ab && k < nb && to < LIM) begin
            if (t.rw) begin
              wv = ($urandom_range(0, 3) != 0);
              wd = t.data[k];
              ws = t.strb[k];
            end else begin
              rr = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk_i);
            to++;
            if (!rst_ni) ab = 1'b1;
            else if (t.rw ? (wv && write_ready[gi]) : (rr && read_valid[gi])) k++;
            @(posedge clk_i); #1;
          end
          // one extra write beat offered after the last one must not be taken
          if (t.rw && hs && !ab) begin
            wv = 1'b1; wd = 16'hDEAD;
            @(negedge clk_i);
            @(posedge clk_i); #1;
          end
          wv = 1'b0; rr = 1'b0;
          ndone++;
        end
      end
    end
  end

  // Downstream responder: random, toggling or always-ready handshakes
  initial begin
    m_req_ready = 1'b0; m_write_ready = 1'b0; m_read_valid = 1'b0; m_read_data = '0;
    forever begin
      @(posedge clk_i); #1;
      m_read_data = DW'($urandom);
      case (ds_mode)
        1: begin
          m_req_ready = 1'b1;
          m_write_ready = ~m_write_ready;
          m_read_valid = ~m_read_valid;
        end
        2: begin
          m_req_ready = 1'b1; m_write_ready = 1'b1; m_read_valid = 1'b1;
        end
        default: begin
          m_req_ready = ($urandom_range(0, 2) != 0);
          m_write_ready = 1'($urandom_range(0, 1));
          m_read_valid = 1'($urandom_range(0, 1));
        end
      endcase
    end
  end

  // Monitor and scoreboard
  initial begin
    bit           act = 1'b0, acc = 1'b0;
    int           own = 0, k = 0, nb = 1, mptr = 0;
    logic [N-1:0] exp_g = '0, oh;
    txn_t         cur;
    forever begin
      @(negedge clk_i);
      if (end_req) break;
      if (!rst_ni) begin
        chk("reset_outputs",
            {grant, req_ready, write_ready, read_valid, m_req_valid, m_req_rw, m_req_burst,
             m_write_valid, m_read_ready, |read_data, |m_req_addr, |m_req_beats,
             |m_write_data, |m_write_strb}, 64'd0);
        act = 1'b0; acc = 1'b0; exp_g = '0; mptr = 0;
      end else begin
        if (!act) begin
          chk("grant_arb", grant, exp_g);
          if (grant != '0) begin
            act = 1'b1; acc = 1'b0; k = 0;
            for (int i = N - 1; i >= 0; i--) if (grant[i]) own = i;
          end else begin
            chk("idle_outputs", {req_ready, write_ready, read_valid, m_req_valid,
                                 m_write_valid, m_read_ready}, 64'd0);
            exp_g = rr_pick(req_valid, mptr);
          end
        end
        if (act) begin
          oh = N'(1) << own;
          chk("grant_hold", grant, oh);
          chk("others_quiet", (req_ready | write_ready | read_valid) & ~oh, 64'd0);
          if (!acc) begin
            chk("req_valid_fwd", m_req_valid, req_valid[own]);
            chk("req_ready_mirror", req_ready, m_req_ready ? oh : '0);
            chk("req_data_gated", {write_ready, read_valid, m_write_valid, m_read_ready}, 64'd0);
            if (m_req_valid && m_req_ready) begin
              if (exp_q[own].size() == 0) begin
                chk("unexpected_req", 64'd1, 64'd0);
                act = 1'b0;
              end else begin
                cur = exp_q[own].pop_front();
                chk("req_fields", {m_req_rw, m_req_addr, m_req_burst, m_req_beats},
                    {cur.rw, cur.addr, cur.burst, cur.beats});
                nb = beats_of(cur);
                acc = 1'b1; k = 0;
              end
            end
          end else if (cur.rw) begin
            chk("wr_ready_mirror", write_ready, m_write_ready ? oh : '0);
            chk("wr_valid_fwd", m_write_valid, write_valid[own]);
            chk("wr_read_gated", {read_valid, m_read_ready, m_req_valid}, 64'd0);
            if (m_write_valid && m_write_ready) begin
              chk("wr_beat", {m_write_data, m_write_strb}, {cur.data[k], cur.strb[k]});
              k++;
            end
          end else begin
            chk("rd_valid_mirror", read_valid, m_read_valid ? oh : '0);
            chk("rd_ready_fwd", m_read_ready, read_ready[own]);
            chk("rd_data", read_data, m_read_data);
            chk("rd_write_gated", {write_ready, m_write_valid, m_req_valid}, 64'd0);
            if (m_read_valid && m_read_ready) k++;
          end
          if (act && acc && k == nb) begin
            act = 1'b0;
            mptr = (own + 1) % N;
            exp_g = '0;
          end
        end
      end
      mon_active = act;
      mon_k = k;
    end
    chk("no_timeout", 64'(tmo), 64'd0);
    chk("txn_closed", 64'(act), 64'd0);
    for (int i = 0; i < N; i++) chk("scoreboard_empty", 64'(exp_q[i].size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Stimulus sequence
  initial begin
    txn_t t;
    int   c;
    repeat (4) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    ds_mode = 2;
    t = mk(1'b1, 32'h0000_1000, 1'b0, 14'd0);
    t.data[0] = 16'hBEEF;
    issue(0, t);
    wait_idle();

    @(posedge clk_i); #2 rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    issue(0, mk(1'b0, 32'h0000_2000, 1'b1, 14'd3));
    issue(1, mk(1'b0, 32'h0000_3000, 1'b1, 14'd3));
    wait_idle();

    ds_mode = 1;
    issue(2, mk(1'b1, 32'h0000_4000, 1'b1, 14'd4));
    wait_idle();

    ds_mode = 2;
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < N; i++) issue(i, mk(1'b0, 32'h0000_5000 + 32'(r * 16 + i), 1'b0, 14'd0));
    wait_idle();

    issue(1, mk(1'b1, 32'h0000_6000, 1'b1, 14'd0));
    wait_idle();

    ds_mode = 0;
    for (int n = 0; n < 60; n++)
      issue($urandom_range(0, N - 1), mk(1'($urandom_range(0, 1)), $urandom,
                                          1'($urandom_range(0, 1)), 14'($urandom_range(0, 8))));
    wait_idle();

    ds_mode = 2;
    issue(0, mk(1'b0, 32'h0000_7000, 1'b0, 14'd0));
    wait_idle();
    issue(1, mk(1'b1, 32'h0000_8000, 1'b1, 14'd8));
    c = 0;
    while (!(mon_active && mon_k >= 2) && c < 500) begin
      @(posedge clk_i);
      c++;
    end
    if (c >= 500) tmo = 1'b1;
    #2 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    issue(0, mk(1'b1, 32'h0000_9000, 1'b0, 14'd0));
    issue(1, mk(1'b1, 32'h0000_A000, 1'b0, 14'd0));
    wait_idle();

    end_req = 1'b1;
  end
endmodule
